muldiv_ctrl: RTL

- Sequences the multi-cycle multiply/divide unit and its HI/LO registers in the 5-stage pipeline.
- Sits in EX, beside the ALU.
- Accepts one operation per start, counts down a fixed latency, commits HI/LO, and raises a stall request toward the hazard logic while an ID-stage instruction touches HI/LO.

---
 rtl/muldiv_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : muldiv_ctrl                                                |
// | Purpose  : EX-stage multiply/divide sequencer owning HI/LO. Computes  |
// |            the 64-bit result at issue, holds it pending for a fixed   |
// |            latency, then commits it; requests ID stalls meanwhile.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        md_valid,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        id_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  counter;
  logic [63:0] pending;
  logic        pending_ok;   // cleared for divide-by-zero: commit leaves HI/LO alone

  logic        is_mul_op;
  logic        is_div_op;
  logic        start;

  logic        sdiv;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] result;
  logic        div_zero;

  assign is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div_op = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign start     = md_valid && (is_mul_op || is_div_op) && !busy;

  // Hold the ID instruction while an operation is issuing or in flight
  assign md_stall = id_md_use && (busy || start);

  // Signed division via magnitudes: quotient truncates toward zero and the
  // remainder follows the dividend's sign. MIN_INT / -1 falls out naturally
  // as quotient 0x80000000, remainder 0.
  assign sdiv     = (md_op == OP_DIV);
  assign neg_q    = sdiv && (src_a[31] ^ src_b[31]);
  assign neg_r    = sdiv && src_a[31];
  assign abs_a    = (sdiv && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign abs_b    = (sdiv && src_b[31]) ? (32'd0 - src_b) : src_b;
  assign div_zero = (src_b == 32'd0);

  // Operation result, selected by the op code presented at issue
  always_comb begin
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (!div_zero) begin
      quot_u = abs_a / abs_b;
      rem_u  = abs_a % abs_b;
    end
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    result = 64'd0;
    case (md_op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV,
      OP_DIVU:  result = {(neg_r ? (32'd0 - rem_u)  : rem_u),
                          (neg_q ? (32'd0 - quot_u) : quot_u)};
      default:  result = 64'd0;
    endcase
  end

  // Issue, count down, commit; mthi/mtlo write directly when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      counter    <= 4'd0;
      pending    <= 64'd0;
      pending_ok <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else if (start) begin
      busy       <= 1'b1;
      counter    <= is_mul_op ? MULT_LOAD : DIV_LOAD;
      pending    <= result;
      pending_ok <= !(is_div_op && div_zero);
    end else if (busy) begin
      counter <= counter - 4'd1;
      if (counter == 4'd1) begin
        busy <= 1'b0;
        if (pending_ok) begin
          hi <= pending[63:32];
          lo <= pending[31:0];
        end
      end
    end else if (md_valid) begin
      if (md_op == OP_MTHI) hi <= src_a;
      if (md_op == OP_MTLO) lo <= src_a;
    end
  end

endmodule
`default_nettype wire
